// File: rtl/trace_capture_buffer.sv
// Trigger-qualified, multi-channel trace capture buffer (linear or circular) with FIFO-order readout.
// Optional TRACE_TIMESTAMP_EN prepends a free-running cycle stamp to every stored word.
module trace_capture_buffer #(
  parameter int Fpay     = 32,
  parameter int TB_DEPTH = 512,
  parameter int CH_NUM   = 5,
  parameter int TS_W     = 16,
  localparam int AW = $clog2(TB_DEPTH),
  localparam int SW = (CH_NUM > 2) ? $clog2(CH_NUM) : 1,
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = Fpay + TS_W
`else
  localparam int DW = Fpay + 0 * TS_W
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CH_NUM*Fpay-1:0] ch_din,
  input  logic [CH_NUM-1:0]      ch_wr,
  input  logic [SW-1:0]          ch_sel,
  input  logic                   mode,
  input  logic                   arm,
  input  logic                   trigger,
  input  logic [AW:0]            post_len,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            ovf_cnt,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(TB_DEPTH);

  state_t          state_r;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r, count_nxt_s, post_cnt_r, post_len_q_r;
  logic [SW-1:0]   ch_sel_q_r;
  logic            mode_q_r, full_r, empty_r, rd_valid_r;
  logic [15:0]     ovf_cnt_r;
  logic [DW-1:0]   rd_data_r, wr_word_s;
  logic [Fpay-1:0] sel_din_s;
  logic            sel_wr_s, capturing_s, readable_s, store_s, wr_en_s, drop_s, rd_fire_s;
  logic [DW-1:0]   mem_r [TB_DEPTH];

  // AND-OR mux of the latched channel; an out-of-range selection stores nothing
  always_comb begin
    sel_wr_s  = 1'b0;
    sel_din_s = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      sel_wr_s  = sel_wr_s | (ch_wr[k] & (ch_sel_q_r == SW'(k)));
      sel_din_s = sel_din_s | (ch_din[k*Fpay +: Fpay] & {Fpay{ch_sel_q_r == SW'(k)}});
    end
  end

  // Capture/readout qualification and next occupancy; arm suppresses both sides
  always_comb begin
    capturing_s = !arm && ((state_r == ARMED) || (state_r == POST));
    readable_s  = !arm && ((state_r == IDLE) || (state_r == DONE));
    store_s     = capturing_s && sel_wr_s;
    wr_en_s     = store_s && (!full_r || mode_q_r);
    drop_s      = store_s && full_r && mode_q_r;
    rd_fire_s   = readable_s && rd_en && !empty_r;
    if (arm) begin
      count_nxt_s = '0;
    end else if (store_s && !full_r) begin
      count_nxt_s = count_r + (AW+1)'(1);
    end else if (rd_fire_s) begin
      count_nxt_s = count_r - (AW+1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;

  // Free-running cycle stamp, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  assign wr_word_s = {ts_r, sel_din_s};
`else
  assign wr_word_s = sel_din_s;
`endif

  // Trace RAM write port (no reset so it maps onto a block RAM)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // Synchronous read port; rd_data holds its last word between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= '0;
    end else if (rd_fire_s) begin
      rd_data_r <= mem_r[rd_ptr_r];
    end
  end

  // Capture FSM, pointers, occupancy flags and overflow counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      rd_valid_r   <= 1'b0;
      ovf_cnt_r    <= 16'd0;
      ch_sel_q_r   <= '0;
      mode_q_r     <= 1'b0;
      post_len_q_r <= '0;
      post_cnt_r   <= '0;
    end else begin
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == DEPTH_C);
      empty_r    <= (count_nxt_s == '0);
      rd_valid_r <= rd_fire_s;
      if (arm) begin
        state_r      <= ARMED;
        wr_ptr_r     <= '0;
        rd_ptr_r     <= '0;
        ovf_cnt_r    <= 16'd0;
        ch_sel_q_r   <= ch_sel;
        mode_q_r     <= mode;
        post_len_q_r <= post_len;
        post_cnt_r   <= '0;
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (drop_s || rd_fire_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        if (store_s && full_r && (ovf_cnt_r != 16'hFFFF)) begin
          ovf_cnt_r <= ovf_cnt_r + 16'd1;
        end
        case (state_r)
          ARMED: begin
            if (trigger) begin
              post_cnt_r <= post_len_q_r;
              state_r    <= (post_len_q_r == '0) ? DONE : POST;
            end
          end
          // Suppressed linear-full stores still consume the post-trigger budget
          POST: begin
            if (store_s) begin
              post_cnt_r <= post_cnt_r - (AW+1)'(1);
              if (post_cnt_r == (AW+1)'(1)) begin
                state_r <= DONE;
              end
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign count    = count_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign ovf_cnt  = ovf_cnt_r;
  assign state    = state_r;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Self-checking bench for trace_capture_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the capture buffer.
module tb_trace_capture_buffer;
  localparam int Fpay = 32, TB_DEPTH = 512, CH_NUM = 5, TS_W = 16;
  localparam int AW = $clog2(TB_DEPTH);
  localparam int SW = (CH_NUM > 2) ? $clog2(CH_NUM) : 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = Fpay + TS_W;
`else
  localparam int DW = Fpay;
`endif

  logic clk, reset;
  logic [CH_NUM*Fpay-1:0] ch_din;
  logic [CH_NUM-1:0] ch_wr;
  logic [SW-1:0] ch_sel;
  logic mode, arm, trigger, rd_en;
  logic [AW:0] post_len;
  logic [DW-1:0] rd_data;
  logic rd_valid, full, empty;
  logic [AW:0] count;
  logic [15:0] ovf_cnt;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: stored words as a queue, FIFO order oldest first
  logic [DW-1:0] m_q[$];
  int m_state, m_ovf, m_sel, m_post;
  bit m_mode, m_rdv;
  logic [DW-1:0] m_rdd;
  logic [TS_W-1:0] m_ts;

  trace_capture_buffer #(.Fpay(Fpay), .TB_DEPTH(TB_DEPTH), .CH_NUM(CH_NUM), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .ch_din(ch_din), .ch_wr(ch_wr), .ch_sel(ch_sel),
    .mode(mode), .arm(arm), .trigger(trigger), .post_len(post_len), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .ovf_cnt(ovf_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q.delete();
    m_state = 0; m_ovf = 0; m_sel = 0; m_post = 0; m_mode = 1'b0;
    m_rdv = 1'b0; m_rdd = '0; m_ts = '0;
  endfunction

  // Applies the spec rules for the inputs present at the coming clock edge
  function automatic void model_update();
    logic [DW-1:0] w;
    int old;
    if (arm) begin
      m_q.delete(); m_ovf = 0; m_sel = int'(ch_sel); m_mode = mode; m_post = int'(post_len);
      m_state = 1; m_rdv = 1'b0;
    end else begin
      old = m_state;
      m_rdv = 1'b0;
      if ((old == 1 || old == 2) && m_sel < CH_NUM && ch_wr[m_sel]) begin
`ifdef TRACE_TIMESTAMP_EN
        w = {m_ts, ch_din[m_sel*Fpay +: Fpay]};
`else
        w = ch_din[m_sel*Fpay +: Fpay];
`endif
        if (m_q.size() < TB_DEPTH) m_q.push_back(w);
        else begin
          if (m_ovf < 65535) m_ovf++;
          if (m_mode) begin
            void'(m_q.pop_front());
            m_q.push_back(w);
          end
        end
        if (old == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      if (old == 1 && trigger) m_state = (m_post == 0) ? 3 : 2;
      if ((old == 0 || old == 3) && rd_en && m_q.size() > 0) begin
        m_rdd = m_q.pop_front();
        m_rdv = 1'b1;
      end
    end
    m_ts = m_ts + 1'b1;
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_wr = '0; arm = 1'b0; trigger = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rand_din();
    for (int k = 0; k < CH_NUM; k++) ch_din[k*Fpay +: Fpay] = $urandom();
  endtask

  task automatic do_arm(input int sel, input bit md, input int pl);
    arm = 1'b1; ch_sel = SW'(sel); mode = md; post_len = (AW+1)'(pl);
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); ch_din = '0; ch_sel = '0; mode = 1'b0; post_len = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
    n_checks++; if (ovf_cnt !== 16'd0 || rd_valid !== 1'b0 || rd_data !== '0) begin n_fail++; $display("FAIL reset_out: ovf=%0d rd_valid=%b rd_data=%0h expected 0/0/0", ovf_cnt, rd_valid, rd_data); end
    #3 reset = 1'b0;
  endtask

  task automatic test_trigger_capture();
    logic [Fpay-1:0] exp_w [8];
    for (int i = 0; i < 5; i++) exp_w[i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 3; i++) exp_w[5+i] = 32'hB0 + 32'(i);
    do_arm(2, 1'b0, 3);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL arm_state: got %0d expected 1", state); end
    for (int i = 0; i < 8; i++) begin
      rand_din();
      ch_din[2*Fpay +: Fpay] = exp_w[i];
      ch_wr = 5'b00101 | 5'($urandom_range(0, 31));
      ch_wr[2] = 1'b1;
      trigger = (i == 4);
      step();
      ch_wr = '0; trigger = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
      if (i == 4) begin
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL post_entry: got %0d expected 2", state); end
      end
    end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL capture_done: got %0d expected 3", state); end
    n_checks++; if (count !== (AW+1)'(8)) begin n_fail++; $display("FAIL capture_count: got %0d expected 8", count); end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; trigger = ($urandom_range(0, 1) == 1);
      step();
      n_checks++; if (rd_valid !== 1'b1 || rd_data[Fpay-1:0] !== exp_w[i]) begin n_fail++; $display("FAIL capture_read%0d: valid=%b data=%0h expected 1/%0h", i, rd_valid, rd_data[Fpay-1:0], exp_w[i]); end
    end
    idle_inputs();
    n_checks++; if (empty !== 1'b1 || count !== '0 || state !== 2'd3) begin n_fail++; $display("FAIL capture_drained: empty=%b count=%0d state=%0d expected 1/0/3", empty, count, state); end
  endtask

  task automatic test_fill(input bit md);
    int bad, first;
    logic [Fpay-1:0] exp_v;
    do_arm(0, md, 0);
    for (int i = 0; i < 520; i++) begin
      rand_din(); ch_din[Fpay-1:0] = 32'(i); ch_wr = 5'b00001;
      step();
    end
    ch_wr = '0;
    n_checks++; if (count !== (AW+1)'(512) || full !== 1'b1 || ovf_cnt !== 16'd8) begin n_fail++; $display("FAIL fill_m%0d: count=%0d full=%b ovf=%0d expected 512/1/8", md, count, full, ovf_cnt); end
    trigger = 1'b1; step(); trigger = 1'b0;
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL fill_done_m%0d: got %0d expected 3", md, state); end
    bad = 0; first = -1;
    for (int i = 0; i < 512; i++) begin
      rd_en = 1'b1; step();
      exp_v = md ? 32'(i + 8) : 32'(i);
      if (rd_valid !== 1'b1 || rd_data[Fpay-1:0] !== exp_v) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    rd_en = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fill_read_m%0d: %0d bad words (first index %0d) expected 0", md, bad, first); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL fill_drain_m%0d: empty=%b full=%b expected 1/0", md, empty, full); end
  endtask

  task automatic test_read_guard();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL rd_empty: valid=%b count=%0d expected 0/0", rd_valid, count); end
    do_arm(1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      rand_din(); ch_wr = 5'b00010; step();
    end
    ch_wr = '0;
    rd_en = 1'b1; step(); step(); rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || count !== (AW+1)'(3)) begin n_fail++; $display("FAIL rd_armed: valid=%b count=%0d expected 0/3", rd_valid, count); end
  endtask

  task automatic test_reset_abort();
    trigger = 1'b1; step(); trigger = 1'b0;
    rand_din(); ch_wr = 5'b00010; step(); ch_wr = '0;
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL abort_pre: got %0d expected 2", state); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    n_checks++; if (state !== 2'd0 || count !== '0 || empty !== 1'b1) begin n_fail++; $display("FAIL abort_reset: state=%0d count=%0d empty=%b expected 0/0/1", state, count, empty); end
    #3 reset = 1'b0;
    arm = 1'b1; trigger = 1'b1; ch_sel = '0; mode = 1'b0; post_len = '0;
    step();
    idle_inputs();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL arm_wins: got %0d expected 1", state); end
    step();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL arm_hold: got %0d expected 1", state); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_arm($urandom_range(0, CH_NUM-1), 1'($urandom_range(0, 1)), $urandom_range(0, 12));
      for (int c = 0; c < 180; c++) begin
        rand_din();
        ch_wr = CH_NUM'($urandom_range(0, 31));
        trigger = ($urandom_range(0, 19) == 0);
        rd_en = (c >= 140) ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state r%0d c%0d: got %0d expected %0d", r, c, state, m_state); end
        n_checks++; if (count !== (AW+1)'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == TB_DEPTH)) begin n_fail++; $display("FAIL rnd_count r%0d c%0d: got %0d expected %0d", r, c, count, m_q.size()); end
        n_checks++; if (ovf_cnt !== 16'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf r%0d c%0d: got %0d expected %0d", r, c, ovf_cnt, m_ovf); end
        n_checks++; if (rd_valid !== m_rdv || (m_rdv && rd_data !== m_rdd)) begin n_fail++; $display("FAIL rnd_read r%0d c%0d: valid=%b data=%0h expected %b/%0h", r, c, rd_valid, rd_data, m_rdv, m_rdd); end
      end
      idle_inputs();
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [TS_W-1:0] ts_a;
    do_arm(0, 1'b0, 0);
    rand_din(); ch_wr = 5'b00001; step(); ch_wr = '0;
    step(); step();
    rand_din(); ch_wr = 5'b00001; step(); ch_wr = '0;
    trigger = 1'b1; step(); trigger = 1'b0;
    rd_en = 1'b1; step();
    ts_a = rd_data[DW-1:Fpay];
    step(); rd_en = 1'b0;
    n_checks++; if (16'(rd_data[DW-1:Fpay] - ts_a) !== 16'd3) begin n_fail++; $display("FAIL ts_delta: got %0d expected 3", 16'(rd_data[DW-1:Fpay] - ts_a)); end
  endtask
`endif

  initial begin
    test_reset();
    test_trigger_capture();
    test_fill(1'b0);
    test_fill(1'b1);
    test_read_guard();
    test_reset_abort();
    test_random();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
